// File: rtl/chunk_serial_adder.sv
// chunk_serial_adder: N-bit add/subtract computed W bits per clock through a
// single W-bit adder slice with a registered carry. A start/busy/done
// handshake frames each operation; S and ovf hold the last completed result.
module chunk_serial_adder #(
    parameter int N = 8,
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         op,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    output logic         busy,
    output logic         done,
    output logic [N:0]   S,
    output logic         ovf
);

    localparam int C     = N / W;
    localparam int CNT_W = (C > 1) ? $clog2(C) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [N-1:0]       opa_q, opa_d;
    logic [N-1:0]       opb_q, opb_d;
    logic [N-1:0]       res_q, res_d;
    logic               carry_q, carry_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               ovf_q, ovf_d;
    logic [N:0]         s_q, s_d;

    logic [W:0]         chunk_sum;
    logic [N-1:0]       res_shift;
    logic               msb_cin;
    logic               last_chunk;

    // Adder slice on the low chunk, plus the result register with the new chunk entering at the MSB side.
    always_comb begin
        chunk_sum  = {1'b0, opa_q[W-1:0]} + {1'b0, opb_q[W-1:0]} + (W+1)'(carry_q);
        res_shift  = (res_q >> W) | (N'(chunk_sum[W-1:0]) << (N - W));
        // Carry into the chunk MSB recovered from its sum bit; on the last chunk this is the carry into bit N-1.
        msb_cin    = chunk_sum[W-1] ^ opa_q[W-1] ^ opb_q[W-1];
        last_chunk = (cnt_q == CNT_W'(C - 1));
    end

    // Next-state and datapath updates; every register holds unless the FSM says otherwise.
    always_comb begin
        state_d = state_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        res_d   = res_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        ovf_d   = ovf_q;
        s_d     = s_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    // Subtraction folds into addition: invert B and inject the +1 as the initial carry.
                    opa_d   = A;
                    opb_d   = B ^ {N{op}};
                    carry_d = op;
                    cnt_d   = '0;
                    res_d   = '0;
                    busy_d  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                opa_d   = opa_q >> W;
                opb_d   = opb_q >> W;
                carry_d = chunk_sum[W];
                res_d   = res_shift;
                cnt_d   = cnt_q + 1'b1;
                if (last_chunk) begin
                    s_d     = {chunk_sum[W], res_shift};
                    ovf_d   = msb_cin ^ chunk_sum[W];
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State, operand, result and handshake registers; async reset clears everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            opa_q   <= '0;
            opb_q   <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            s_q     <= '0;
        end else begin
            state_q <= state_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
            s_q     <= s_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign S    = s_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_chunk_serial_adder.sv
// Bench for chunk_serial_adder: four instances at N=8 with W = 1, 2, 4, 8
// share one stimulus stream; directed cases target the W=2 instance and the
// random sweep checks every instance against an arithmetic reference.
module tb_chunk_serial_adder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       op;
    logic [7:0] a_in;
    logic [7:0] b_in;
    logic [3:0] busy_v;
    logic [3:0] done_v;
    logic [3:0] ovf_v;
    logic [8:0] s_v [4];

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        chunk_serial_adder #(.N(8), .W(1 << g)) u_dut (
            .clk   (clk),
            .rst_n (rst_n),
            .start (start),
            .op    (op),
            .A     (a_in),
            .B     (b_in),
            .busy  (busy_v[g]),
            .done  (done_v[g]),
            .S     (s_v[g]),
            .ovf   (ovf_v[g])
        );
    end

    task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: {ovf, S} from plain integer arithmetic.
    function automatic logic [9:0] ref_model(input logic [7:0] a, input logic [7:0] b, input logic o);
        int         ua, ub, sa, sb, r;
        logic [8:0] s;
        logic       v;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        if (!o) begin
            s = 9'(ua + ub);
            r = sa + sb;
        end else begin
            s = 9'(ua + 256 - ub);
            r = sa - sb;
        end
        v = (r > 127) || (r < -128);
        return {v, s};
    endfunction

    // One operation on all instances; instance g must finish exactly 8>>g edges after acceptance.
    task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b, input logic o);
        logic [9:0] exp;
        exp   = ref_model(a, b, o);
        a_in  = a;
        b_in  = b;
        op    = o;
        start = 1'b1;
        tick();
        start = 1'b0;
        a_in  = $urandom;
        b_in  = $urandom;
        op    = $urandom;
        for (int g = 0; g < 4; g++) begin
            chk($sformatf("%s busy0 W%0d", tag, 1 << g), {8'd0, busy_v[g]}, 9'd1);
        end
        for (int i = 1; i <= 8; i++) begin
            tick();
            for (int g = 0; g < 4; g++) begin
                int c;
                c = 8 >> g;
                if (i <= c) begin
                    chk($sformatf("%s done c%0d W%0d", tag, i, 1 << g), {8'd0, done_v[g]}, {8'd0, i == c});
                    chk($sformatf("%s busy c%0d W%0d", tag, i, 1 << g), {8'd0, busy_v[g]}, {8'd0, i < c});
                end
                if (i == c) begin
                    chk($sformatf("%s S W%0d", tag, 1 << g), s_v[g], exp[8:0]);
                    chk($sformatf("%s ovf W%0d", tag, 1 << g), {8'd0, ovf_v[g]}, {8'd0, exp[9]});
                end
            end
        end
    endtask

    initial begin
        rst_n = 1'b1;
        start = 1'b0;
        op    = 1'b0;
        a_in  = '0;
        b_in  = '0;

        // Power-on reset: outputs clear asynchronously before any clock edge.
        #1 rst_n = 1'b0;
        #1;
        chk("por busy", {8'd0, busy_v[1]}, 9'd0);
        chk("por done", {8'd0, done_v[1]}, 9'd0);
        chk("por S", s_v[1], 9'h000);
        chk("por ovf", {8'd0, ovf_v[1]}, 9'd0);
        tick();
        tick();
        #2 rst_n = 1'b1;
        tick();

        // Directed arithmetic cases.
        run_op("add_carry", 8'hFF, 8'h01, 1'b0);
        tick();
        tick();
        chk("add_carry hold S", s_v[1], 9'h100);
        chk("add_carry hold done", {8'd0, done_v[1]}, 9'd0);
        run_op("sub_borrow", 8'h05, 8'h07, 1'b1);
        chk("sub_borrow S const", s_v[1], 9'h0FE);
        run_op("sub_noborrow", 8'h07, 8'h05, 1'b1);
        chk("sub_noborrow S const", s_v[1], 9'h102);
        run_op("ovf_add", 8'h7F, 8'h01, 1'b0);
        chk("ovf_add S const", s_v[1], 9'h080);
        chk("ovf_add ovf const", {8'd0, ovf_v[1]}, 9'd1);
        run_op("ovf_sub", 8'h80, 8'h01, 1'b1);
        chk("ovf_sub S const", s_v[1], 9'h17F);
        chk("ovf_sub ovf const", {8'd0, ovf_v[1]}, 9'd1);

        // start held through RUN and into the done cycle (W=2 instance).
        a_in  = 8'h33;
        b_in  = 8'h11;
        op    = 1'b0;
        start = 1'b1;
        tick();
        a_in = 8'h10;
        b_in = 8'h20;
        for (int i = 1; i <= 9; i++) begin
            tick();
            if (i == 5) begin
                start = 1'b0;
                chk("held busy restart", {8'd0, busy_v[1]}, 9'd1);
            end
            chk($sformatf("held done c%0d", i), {8'd0, done_v[1]}, {8'd0, (i == 4) || (i == 9)});
            if (i == 4) chk("held first S", s_v[1], 9'h044);
            if (i == 9) chk("held b2b S", s_v[1], 9'h030);
        end
        for (int i = 0; i < 10; i++) tick();

        // Reset in the second RUN cycle: immediate clear, no done afterwards.
        a_in  = 8'h3C;
        b_in  = 8'h5A;
        op    = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk("midrst busy", {8'd0, busy_v[1]}, 9'd0);
        chk("midrst done", {8'd0, done_v[1]}, 9'd0);
        chk("midrst S", s_v[1], 9'h000);
        chk("midrst ovf", {8'd0, ovf_v[1]}, 9'd0);
        #2 rst_n = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            chk($sformatf("postrst done c%0d", i), {8'd0, done_v[1]}, 9'd0);
            chk($sformatf("postrst S c%0d", i), s_v[1], 9'h000);
        end

        // Random sweep across all widths.
        for (int n = 0; n < 200; n++) begin
            logic [7:0] ra, rb;
            logic       ro;
            ra = 8'($urandom);
            rb = 8'($urandom);
            ro = 1'($urandom);
            run_op($sformatf("rnd%0d", n), ra, rb, ro);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
